// File: rtl/case_2_mul_pipe_sat.sv
// Pipelined signed multiplier with clock-enable stall, valid tracking and
// selectable output narrowing (wrap, saturate, round-half-up then saturate).
module case_2_mul_pipe_sat #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 11,
  parameter int SHIFT      = 4,
  parameter int MODE       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_vld,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  input  logic                         clr_ovf,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         out_vld,
  output logic                         ovf,
  output logic                         ovf_sticky
);

  localparam int P   = din0_WIDTH + din1_WIDTH;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [P:0] RND  = (MODE == 2 && SHIFT > 0) ? (P+1)'(64'sd1 <<< RSH) : '0;
  localparam logic signed [P:0] MAXV = (P+1)'((64'sd1 <<< (dout_WIDTH - 1)) - 64'sd1);
  localparam logic signed [P:0] MINV = ~MAXV;

  if (NUM_STAGE < 2 || NUM_STAGE > 6 || SHIFT < 0 || SHIFT > P - 1 ||
      dout_WIDTH > P - SHIFT || MODE < 0 || MODE > 2 || ID < 0) begin : g_bad_param
    $error("case_2_mul_pipe_sat: illegal parameter combination");
  end

  // Stage 1: operand and valid capture
  logic signed [din0_WIDTH-1:0] a_q;
  logic signed [din1_WIDTH-1:0] b_q;
  logic                         vld1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      vld1_q <= 1'b0;
    end else if (ce) begin
      a_q    <= din0;
      b_q    <= din1;
      vld1_q <= in_vld;
    end
  end

  logic signed [P-1:0] prod;
  assign prod = P'(a_q) * P'(b_q);

  logic signed [P-1:0] tap_prod;
  logic                tap_vld;

  // Stages 2..NUM_STAGE-1 carry the full product; absent when NUM_STAGE is 2
  if (NUM_STAGE > 2) begin : g_mid
    localparam int D = NUM_STAGE - 2;
    logic signed [P-1:0] prod_q [D];
    logic                vld_q  [D];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < D; k++) begin
          prod_q[k] <= '0;
          vld_q[k]  <= 1'b0;
        end
      end else if (ce) begin
        prod_q[0] <= prod;
        vld_q[0]  <= vld1_q;
        for (int k = 1; k < D; k++) begin
          prod_q[k] <= prod_q[k-1];
          vld_q[k]  <= vld_q[k-1];
        end
      end
    end

    assign tap_prod = prod_q[D-1];
    assign tap_vld  = vld_q[D-1];
  end else begin : g_nomid
    assign tap_prod = prod;
    assign tap_vld  = vld1_q;
  end

  // Narrowing works in P+1 bits so the rounding increment can never overflow
  logic signed [P:0]            ext;
  logic signed [P:0]            s;
  logic                         too_hi;
  logic                         too_lo;
  logic                         ovf_n;
  logic signed [dout_WIDTH-1:0] dout_n;

  always_comb begin
    ext    = {tap_prod[P-1], tap_prod} + RND;
    s      = ext >>> SHIFT;
    too_hi = (s > MAXV);
    too_lo = (s < MINV);
    ovf_n  = too_hi | too_lo;
    dout_n = s[dout_WIDTH-1:0];
    if (MODE != 0) begin
      if (too_hi)      dout_n = MAXV[dout_WIDTH-1:0];
      else if (too_lo) dout_n = MINV[dout_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout    <= '0;
      out_vld <= 1'b0;
      ovf     <= 1'b0;
    end else if (ce) begin
      dout    <= dout_n;
      out_vld <= tap_vld;
      ovf     <= tap_vld & ovf_n;
    end
  end

  // Set has priority over clear; clear acts even while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
    end else if (ce && tap_vld && ovf_n) begin
      ovf_sticky <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule
